// File: rtl/kbd_pkg.sv
// Shared types for the keyboard matrix scanner: row count, idle select code,
// the key-event record and the scanner state encoding.
package kbd_pkg;
  localparam int         ROW_COUNT = 9;
  localparam logic [3:0] IDLE_ROW  = 4'hF;

  typedef struct packed {
    logic [3:0] row;
    logic [2:0] col;
    logic       pressed;
  } key_evt_t;

  typedef enum logic [2:0] {
    IDLE, SELECT, SETTLE, SAMPLE, EMIT, NEXT, GAP
  } scan_state_t;

  // Index of the least significant set bit (0 when none are set).
  function automatic logic [2:0] lowest_bit(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/kbd_matrix_scan_if.sv
// Key-event valid/ready channel from the scanner to its consumer.
interface kbd_matrix_scan_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_row;
  logic [2:0] evt_col;
  logic       evt_pressed;

  modport master (output evt_valid, evt_row, evt_col, evt_pressed, input evt_ready);
  modport slave  (input evt_valid, evt_row, evt_col, evt_pressed, output evt_ready);
endinterface

// File: rtl/kbd_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  key_evt_t push_data,
  output logic     full,
  input  logic     pop,
  output key_evt_t head,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  key_evt_t      mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so nothing stale is ever presented.
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/kbd_matrix_scan.sv
// Keyboard matrix scanner: walks rows 0..8 through the PPI, debounces each
// row over two consecutive scans and queues press/release events.
module kbd_matrix_scan
  import kbd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SCAN_GAP      = 256,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  output logic [3:0]        ppi_port_c,
  input  logic [7:0]        ppi_port_b,
  output logic              busy,
  kbd_matrix_scan_if.master evt
);
  scan_state_t state, state_nxt;
  logic [3:0]  row;
  logic [3:0]  settle_cnt;
  logic [15:0] gap_cnt;
  logic [7:0]  raw    [ROW_COUNT];
  logic [7:0]  stable [ROW_COUNT];
  logic [7:0]  sample, pend, diff_now;
  logic [2:0]  col;
  logic        fifo_full, fifo_empty, pop, push, last_bit;
  key_evt_t    push_evt, head;

  // A row only reports a change once two consecutive samples agree.
  assign diff_now   = (ppi_port_b == raw[row]) ? (ppi_port_b ^ stable[row]) : 8'h00;
  assign col        = lowest_bit(pend);
  assign last_bit   = ((pend & (pend - 8'd1)) == 8'h00);
  assign pop        = evt.evt_valid && evt.evt_ready;
  assign push       = (state == EMIT) && (!fifo_full || pop);
  assign push_evt   = '{row: row, col: col, pressed: ~sample[col]};
  assign ppi_port_c = (state == IDLE || state == GAP) ? IDLE_ROW : row;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scan_en) state_nxt = SELECT;
      SELECT:  state_nxt = (SETTLE_CYCLES > 1) ? SETTLE : SAMPLE;
      SETTLE:  if (settle_cnt == 4'd0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (diff_now != 8'h00) ? EMIT : NEXT;
      EMIT:    if (push && last_bit) state_nxt = NEXT;
      NEXT: begin
        if (!scan_en)                            state_nxt = IDLE;
        else if (row == 4'(ROW_COUNT - 1))       state_nxt = (SCAN_GAP > 0) ? GAP : SELECT;
        else                                     state_nxt = SELECT;
      end
      GAP:     if (gap_cnt == 16'd0) state_nxt = scan_en ? SELECT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row        <= 4'd0;
      settle_cnt <= 4'd0;
      gap_cnt    <= 16'd0;
      sample     <= 8'hFF;
      pend       <= 8'h00;
      for (int r = 0; r < ROW_COUNT; r++) begin
        raw[r]    <= 8'hFF;
        stable[r] <= 8'hFF;
      end
    end else begin
      state <= state_nxt;
      case (state)
        SELECT: settle_cnt <= 4'(SETTLE_CYCLES - 2);
        SETTLE: settle_cnt <= settle_cnt - 4'd1;
        SAMPLE: begin
          sample   <= ppi_port_b;
          raw[row] <= ppi_port_b;
          pend     <= diff_now;
        end
        // Stable follows the queue one bit at a time and holds while stalled.
        EMIT: if (push) begin
          pend[col]        <= 1'b0;
          stable[row][col] <= sample[col];
        end
        NEXT: begin
          row     <= (!scan_en || row == 4'(ROW_COUNT - 1)) ? 4'd0 : row + 4'd1;
          gap_cnt <= 16'(SCAN_GAP - 1);
        end
        GAP:     gap_cnt <= gap_cnt - 16'd1;
        default: ;
      endcase
    end
  end

  kbd_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_evt),
    .full      (fifo_full),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign evt.evt_valid   = !fifo_empty;
  assign evt.evt_row     = head.row;
  assign evt.evt_col     = head.col;
  assign evt.evt_pressed = head.pressed;
endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Scoreboarded bench: a keyboard-matrix responder model drives port B, expected
// events are queued with the stimulus and a monitor checks every transfer.
module tb_kbd_matrix_scan;
  import kbd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_en = 1'b0;
  logic [3:0] ppi_port_c;
  logic [7:0] ppi_port_b;
  logic       busy;
  logic [7:0] keys [9];
  key_evt_t   sb [$];
  int         total = 0;
  int         bad = 0;

  kbd_matrix_scan_if evt_bus ();

  kbd_matrix_scan #(.SETTLE_CYCLES(4), .SCAN_GAP(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .ppi_port_c (ppi_port_c),
    .ppi_port_b (ppi_port_b),
    .busy       (busy),
    .evt        (evt_bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    ppi_port_b = 8'hFF;
    for (int r = 0; r < 9; r++) if (ppi_port_c == 4'(r)) ppi_port_b = keys[r];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input int r, input int c, input logic p);
    key_evt_t e;
    e.row = 4'(r); e.col = 3'(c); e.pressed = p;
    sb.push_back(e);
  endtask

  // Monitor: pops on each transfer, and checks the head holds while stalled.
  key_evt_t held;
  logic     stalled = 1'b0;
  always @(negedge clk) begin
    key_evt_t got, want;
    got.row = evt_bus.evt_row; got.col = evt_bus.evt_col; got.pressed = evt_bus.evt_pressed;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) chk("hold_stable", {23'd0, evt_bus.evt_valid, got}, {23'd0, 1'b1, held});
      if (evt_bus.evt_valid && evt_bus.evt_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_evt: got row=%0d col=%0d pressed=%0d want none",
                   got.row, got.col, got.pressed);
        end else begin
          want = sb.pop_front();
          chk("evt", 32'(got), 32'(want));
        end
      end
      stalled = evt_bus.evt_valid && !evt_bus.evt_ready;
      held    = got;
    end
  end

  task automatic wait_row_start(input logic [3:0] r);
    logic [3:0] prev;
    prev = ppi_port_c;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (ppi_port_c == r && prev != r) return;
      prev = ppi_port_c;
    end
    total++; bad++;
    $display("FAIL wait_row_%0d: got timeout want row select", r);
  endtask

  task automatic wait_scan_end();
    logic [3:0] prev;
    prev = ppi_port_c;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (prev == 4'd8 && ppi_port_c == 4'hF) return;
      prev = ppi_port_c;
    end
    total++; bad++;
    $display("FAIL wait_scan_end: got timeout want scan end");
  endtask

  task automatic scans(input int n);
    for (int i = 0; i < n; i++) wait_scan_end();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    for (int r = 0; r < 9; r++) keys[r] = 8'hFF;
    evt_bus.evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_port_c", ppi_port_c, 4'hF);
    chk("rst_valid", evt_bus.evt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fields", {evt_bus.evt_row, evt_bus.evt_col, evt_bus.evt_pressed}, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_port_c", ppi_port_c, 4'hF);
    scan_en = 1'b1;

    // Single press then release on row 3 column 5.
    wait_scan_end();
    keys[3] = 8'hDF; expect_evt(3, 5, 1'b1);
    scans(2);
    keys[3] = 8'hFF; expect_evt(3, 5, 1'b0);
    scans(3);
    chk("single_drained", sb.size(), 0);

    // Bounce: present for one scan only.
    keys[6] = 8'hFE;
    wait_scan_end();
    keys[6] = 8'hFF;
    scans(2);
    chk("bounce_drained", sb.size(), 0);

    // Multi-bit row 8 reported in ascending column order.
    keys[8] = 8'b0110_1110;
    expect_evt(8, 0, 1'b1); expect_evt(8, 4, 1'b1); expect_evt(8, 7, 1'b1);
    scans(2);
    chk("multi_press_drained", sb.size(), 0);
    keys[8] = 8'hFF;
    expect_evt(8, 0, 1'b0); expect_evt(8, 4, 1'b0); expect_evt(8, 7, 1'b0);
    scans(2);
    chk("multi_rel_drained", sb.size(), 0);

    // Sampling point: a change at cycle 3 is seen, at cycle 5 it is not.
    keys[1] = 8'hFB;
    wait_scan_end();
    wait_row_start(4'd1);
    repeat (3) @(posedge clk);
    #1 keys[1] = 8'hFF;
    scans(3);
    chk("early_change_drained", sb.size(), 0);
    keys[1] = 8'hFB;
    wait_scan_end();
    expect_evt(1, 2, 1'b1);
    wait_row_start(4'd1);
    repeat (5) @(posedge clk);
    #1 keys[1] = 8'hFF;
    expect_evt(1, 2, 1'b0);
    scans(3);
    chk("late_change_drained", sb.size(), 0);

    // Backpressure: six presses on row 2, FIFO holds four, scanner stalls.
    evt_bus.evt_ready = 1'b0;
    keys[2] = 8'hC0;
    for (int c = 0; c < 6; c++) expect_evt(2, c, 1'b1);
    wait_scan_end();
    wait_row_start(4'd2);
    repeat (12) @(posedge clk);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ppi_port_c == 4'd2 && busy) hits++;
    end
    chk("stall_cycles", hits, 20);
    chk("stall_head", {evt_bus.evt_valid, evt_bus.evt_row, evt_bus.evt_col, evt_bus.evt_pressed},
        {1'b1, 4'd2, 3'd0, 1'b1});
    evt_bus.evt_ready = 1'b1;
    wait_scan_end();
    chk("bp_drained", sb.size(), 0);
    keys[2] = 8'hFF;
    for (int c = 0; c < 6; c++) expect_evt(2, c, 1'b0);
    scans(2);
    chk("bp_rel_drained", sb.size(), 0);

    // scan_en dropped at row 4: rows 5..8 never selected.
    wait_row_start(4'd4);
    scan_en = 1'b0;
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ppi_port_c >= 4'd5 && ppi_port_c <= 4'd8) hits++;
    end
    chk("stop_rows_5_8", hits, 0);
    chk("stop_busy", busy, 0);
    chk("stop_port_c", ppi_port_c, 4'hF);
    scan_en = 1'b1;
    for (int i = 0; i < 10 && ppi_port_c == 4'hF; i++) begin
      @(posedge clk); #1;
    end
    chk("restart_row", ppi_port_c, 4'd0);

    // Reset mid-SETTLE with an event pending in the FIFO.
    evt_bus.evt_ready = 1'b0;
    wait_scan_end();
    keys[0] = 8'hFE;
    wait_scan_end();
    wait_row_start(4'd1);
    chk("pre_rst_valid", evt_bus.evt_valid, 1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_port_c", ppi_port_c, 4'hF);
    chk("mid_rst_valid", evt_bus.evt_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fields", {evt_bus.evt_row, evt_bus.evt_col, evt_bus.evt_pressed}, 0);
    keys[0] = 8'hFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    evt_bus.evt_ready = 1'b1;
    scans(3);
    chk("post_rst_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kbd_matrix_scan.md
KBD_MATRIX_SCAN -- requirements
Module: kbd_matrix_scan

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles from row select to sampling port B, range 1..15.
REQ-002 SHALL have parameter SCAN_GAP, default 256: idle cycles between the end of row 8 and the next row 0, range 0..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries, a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port scan_en, input, 1 bit: enables scanning.
REQ-007 SHALL have port ppi_port_c, output, 4 bits: keyboard row select driven to the matrix responder.
REQ-008 SHALL have port ppi_port_b, input, 8 bits: row data from the responder, active-low, bit n = column n.
REQ-009 SHALL have port evt_valid, output, 1 bit: a key event is available at the FIFO head.
REQ-010 SHALL have port evt_ready, input, 1 bit: the consumer accepts the head event.
REQ-011 SHALL have port evt_row, output, 4 bits: row of the head event.
REQ-012 SHALL have port evt_col, output, 3 bits: column of the head event.
REQ-013 SHALL have port evt_pressed, output, 1 bit: 1 = press, 0 = release.
REQ-014 SHALL have port busy, output, 1 bit: FSM is not in IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, SELECT, SETTLE, SAMPLE, EMIT, NEXT and GAP.
REQ-016 SHALL go IDLE->SELECT with row=0 when scan_en=1; otherwise stay in IDLE with ppi_port_c=4'hF.
REQ-017 SHALL drive ppi_port_c=row from SELECT through EMIT, and 4'hF in IDLE and GAP.
REQ-018 SHALL spend SELECT 1 cycle, then SETTLE for SETTLE_CYCLES-1 cycles, registering ppi_port_b in SAMPLE exactly SETTLE_CYCLES cycles after SELECT is entered.
REQ-019 SHALL keep per-row raw[9] and stable[9] registers, both 8'hFF after reset.
REQ-020 SHALL, in SAMPLE, set raw[row]=sample, and SHALL set diff=sample^stable[row] when sample==previous raw[row] (debounce over two consecutive scans); otherwise diff=0.
REQ-021 SHALL, in EMIT, enqueue one event per cycle for each set diff bit in ascending column order: pressed=~sample[col], row=row, col=col.
REQ-022 SHALL update stable[row] bit-by-bit as each event is enqueued, so stable never leads the FIFO contents.
REQ-023 SHALL hold EMIT without dropping events while the FIFO is full; stable and ppi_port_c are held during the stall.
REQ-024 SHALL go SAMPLE->NEXT directly when diff==0, and EMIT->NEXT after the last set bit is enqueued.
REQ-025 SHALL go NEXT->SELECT with row+1 for rows 0..7; after row 8 it SHALL enter GAP for SCAN_GAP cycles, then go to SELECT with row=0, or to IDLE if scan_en=0.
REQ-026 SHALL treat scan_en=0 mid-scan as completing the current row (including EMIT), then entering IDLE with the row counter cleared; debounce state is retained.
REQ-027 SHALL give the FIFO a valid/ready handshake: transfer when evt_valid & evt_ready; evt_* stable while evt_valid=1 and not accepted; first enqueued event visible on evt_valid the cycle after its EMIT cycle.
REQ-028 SHALL allow a simultaneous FIFO push and pop when full, so no stall occurs in that cycle.

Reset
REQ-029 SHALL, on rst, immediately force: state IDLE, row 0, ppi_port_c=4'hF, evt_valid=0, evt_row=0, evt_col=0, evt_pressed=0, busy=0, FIFO empty, all raw and stable = 8'hFF.
REQ-030 SHALL, on rst asserted mid-scan or mid-EMIT, discard pending events, with no partial event visible after release.

Structure
REQ-031 SHALL place the following in shared package kbd_pkg: ROW_COUNT=9, IDLE_ROW=4'hF, the key-event struct (row, col, pressed) and the scanner state enum.
REQ-032 SHALL implement the event FIFO as sub-module kbd_evt_fifo (parameter DEPTH, first-word-fall-through, push/full and pop/empty).

Verification
REQ-033 SHALL verify reset defaults: rst pulse mid-SETTLE -> ppi_port_c=F, evt_valid=0 and busy=0 within the same cycle; no events after release.
REQ-034 SHALL verify a single press: the responder holds row 3, column 5 low for 2 full scans -> exactly one event {row=3, col=5, pressed=1}; releasing it for 2 scans -> {3,5,0}.
REQ-035 SHALL verify debounce: row 6 column 0 low for only 1 scan -> no event.
REQ-036 SHALL verify multi-bit ordering: row 8 = 8'b0110_1110 stable -> events for cols 0, 4 and 7 in that order, each pressed=1.
REQ-037 SHALL verify backpressure: FIFO_DEPTH=4, evt_ready=0, 6 simultaneous presses on row 2 -> 4 queued, FSM stalls in EMIT with ppi_port_c=2; raising evt_ready -> all 6 delivered in order with none lost.
REQ-038 SHALL verify timing: SETTLE_CYCLES=4 -> port B is sampled 4 cycles after ppi_port_c changes, checked by changing port B at cycle 3 vs. cycle 5; scan_en=0 at row 4 -> rows 5..8 are never selected.
